// File: rtl/ntt_agu_pkg.sv
// ntt_agu_pkg: shared types, constants and helpers for the radix-16 NTT
// address generator.
//   - RADIX/LANES constants, FSM state enum
//   - per-lane MA/BN array typedefs and the write-back pipe entry
//   - num_stages/stage_width sizing helpers, digit_sum_mod16 bank hash
// MA_width/BANK_width default to a 4096-point memory (8-bit MA, 4-bit bank).
`ifndef MA_width
`define MA_width 8
`endif
`ifndef BANK_width
`define BANK_width 4
`endif

package ntt_agu_pkg;

  localparam int unsigned RADIX = 16;
  localparam int unsigned LANES = 16;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} agu_state_t;

  typedef logic [LANES-1:0][`MA_width-1:0]   ma_lane_t;
  typedef logic [LANES-1:0][`BANK_width-1:0] bn_lane_t;

  typedef struct packed {
    logic     valid;
    ma_lane_t ma;
    bn_lane_t bn;
  } wb_entry_t;

  function automatic int unsigned num_stages(input int unsigned n);
    return $clog2(n) / $clog2(RADIX);
  endfunction

  function automatic int unsigned stage_width(input int unsigned n);
    return $clog2(num_stages(n)) + 1;
  endfunction

  // Sum of all radix-16 digits, wrapping mod 16; leading zero digits add nothing.
  function automatic logic [3:0] digit_sum_mod16(input logic [31:0] v);
    logic [3:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) s = s + v[4*i +: 4];
    return s;
  endfunction

endpackage

// File: rtl/ntt_mem_agu_if.sv
// ntt_mem_agu_if: control and address bus between the AGU and the 16-bank
// memory. master = AGU side, slave = memory / test side.
//   start, busy, done, stage_idx, LAST_STAGE : sequencing
//   r_enable, MA_idx, BN_idx                 : read issue, 16 lanes
//   w_enable, R16_w_MA_idx, R16_w_BN_idx     : write-back issue, 16 lanes
interface ntt_mem_agu_if
  import ntt_agu_pkg::*;
#(
  parameter int unsigned N = 4096
);
  localparam int unsigned SW = stage_width(N);

  logic          start;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage_idx;
  logic          LAST_STAGE;
  logic          r_enable;
  ma_lane_t      MA_idx;
  bn_lane_t      BN_idx;
  logic          w_enable;
  ma_lane_t      R16_w_MA_idx;
  bn_lane_t      R16_w_BN_idx;

  modport master (
    input  start,
    output busy, done, stage_idx, LAST_STAGE,
    output r_enable, MA_idx, BN_idx,
    output w_enable, R16_w_MA_idx, R16_w_BN_idx
  );

  modport slave (
    output start,
    input  busy, done, stage_idx, LAST_STAGE,
    input  r_enable, MA_idx, BN_idx,
    input  w_enable, R16_w_MA_idx, R16_w_BN_idx
  );
endinterface

// File: rtl/ntt_bank_map.sv
// ntt_bank_map: combinational lane address for one butterfly lane.
//   g   : group number within the stage
//   pos : radix-16 digit position the butterfly spans (S-1-stage)
//   ma  : memory address (idx >> 4)
//   bn  : bank (digit sum of idx mod 16)
// LANE selects which value of the spanned digit this instance produces.
module ntt_bank_map
  import ntt_agu_pkg::*;
#(
  parameter int unsigned N    = 4096,
  parameter int unsigned LANE = 0
) (
  input  logic [$clog2(N)-5:0]      g,
  input  logic [stage_width(N)-1:0] pos,
  output logic [`MA_width-1:0]      ma,
  output logic [`BANK_width-1:0]    bn
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] gx, hi, mid, lo, idx;

  // Insert the lane digit at position pos, splitting g around it.
  always_comb begin
    gx  = IW'(g);
    hi  = (gx >> (4*pos)) << (4*(pos+1));
    mid = IW'(LANE) << (4*pos);
    lo  = gx & ((IW'(1) << (4*pos)) - IW'(1));
    idx = hi | mid | lo;
    ma  = `MA_width'(idx >> 4);
    bn  = `BANK_width'(digit_sum_mod16(32'(idx)));
  end
endmodule

// File: rtl/ntt_mem_agu.sv
// ntt_mem_agu: conflict-free address generator for in-place radix-16 NTT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ntt_mem_agu_if.master (start/busy/done/stage, read lanes,
//              write-back lanes delayed PIPE_LAT cycles)
// Each stage issues N/16 groups on consecutive cycles, then drains the
// write pipe before the next stage's first read.
module ntt_mem_agu
  import ntt_agu_pkg::*;
#(
  parameter int unsigned N        = 4096,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  ntt_mem_agu_if.master       bus
);
  localparam int unsigned S  = num_stages(N);
  localparam int unsigned SW = stage_width(N);
  localparam int unsigned GW = $clog2(N) - 4;
  localparam logic [GW-1:0] G_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(S - 1);

  agu_state_t    state;
  logic [GW-1:0] g;
  logic [SW-1:0] iss_stage, iss_pos;
  logic [GW-1:0] iss_g;
  ma_lane_t      map_ma;
  bn_lane_t      map_bn;
  wb_entry_t     pipe [PIPE_LAT];
  logic          pending;

  // The group that would be issued on this edge, whatever the state does with it.
  always_comb begin
    iss_stage = bus.stage_idx;
    iss_g     = g;
    case (state)
      IDLE:    begin iss_stage = '0; iss_g = '0; end
      DRAIN:   begin iss_stage = bus.stage_idx + SW'(1); iss_g = '0; end
      default: ;
    endcase
    iss_pos = S_LAST - iss_stage;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    ntt_bank_map #(.N(N), .LANE(j)) u_map (
      .g   (iss_g),
      .pos (iss_pos),
      .ma  (map_ma[j]),
      .bn  (map_bn[j])
    );
  end

  // Writes still to come after this edge: the read on the bus now plus
  // every pipe slot except the one currently driving the write port.
  always_comb begin
    pending = bus.r_enable;
    for (int unsigned k = 0; k + 1 < PIPE_LAT; k++) pending = pending | pipe[k].valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      g              <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.stage_idx  <= '0;
      bus.LAST_STAGE <= 1'b0;
      bus.r_enable   <= 1'b0;
      bus.MA_idx     <= '0;
      bus.BN_idx     <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.r_enable <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state          <= READ;
          bus.busy       <= 1'b1;
          bus.r_enable   <= 1'b1;
          bus.MA_idx     <= map_ma;
          bus.BN_idx     <= map_bn;
          bus.stage_idx  <= iss_stage;
          bus.LAST_STAGE <= (iss_stage == S_LAST);
          g              <= GW'(1);
        end
        READ: begin
          bus.r_enable <= 1'b1;
          bus.MA_idx   <= map_ma;
          bus.BN_idx   <= map_bn;
          g            <= g + GW'(1);
          if (g == G_LAST) state <= DRAIN;
        end
        DRAIN: if (!pending) begin
          if (bus.stage_idx == S_LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state          <= READ;
            bus.r_enable   <= 1'b1;
            bus.MA_idx     <= map_ma;
            bus.BN_idx     <= map_bn;
            bus.stage_idx  <= iss_stage;
            bus.LAST_STAGE <= (iss_stage == S_LAST);
            g              <= GW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {bus.r_enable, bus.MA_idx, bus.BN_idx};
      for (int unsigned k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign bus.w_enable     = pipe[PIPE_LAT-1].valid;
  assign bus.R16_w_MA_idx = pipe[PIPE_LAT-1].ma;
  assign bus.R16_w_BN_idx = pipe[PIPE_LAT-1].bn;
endmodule

// File: doc/ntt_mem_agu.md
# ntt_mem_agu

Conflict-free address generator that drives `memory_wrapper` for radix-16 in-place NTT. For every butterfly group it issues 16 read addresses in one cycle, one per lane, as an (MA, BN) pair. It issues the matching 16 write-back addresses PIPE_LAT cycles later on the R16_w_* ports. It steps through all stages and flags the final one on LAST_STAGE. It is the initiator that sits in front of the 16-bank memory and replaces hand-driven index stimulus.

## Interface
- N, 4096: transform length; must be a power of 16, with N ≥ 256.
- PIPE_LAT, 4: cycles from a read issue to the matching write issue (memory read latency plus radix-16 PE latency); must be ≥ 1.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last write of the last stage has been issued.
- stage_idx  out  $clog2(S)+1  current stage, with S = log16(N).
- LAST_STAGE  out  1  high while stage_idx == S-1.
- r_enable  out  1  read-issue valid.
- MA0_idx..MA15_idx  out  `MA_width each  read memory address, lane j.
- BN0_idx..BN15_idx  out  `BANK_width (4) each  read bank, lane j.
- w_enable  out  1  write-issue valid.
- R16_w_MA0_idx..R16_w_MA15_idx  out  `MA_width each  write address, lane j.
- R16_w_BN0_idx..R16_w_BN15_idx  out  `BANK_width each  write bank, lane j.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 → READ, with stage=0 and group g=0.
- READ: issues group g each cycle. On the last group, g=N/16-1, → DRAIN.
- DRAIN: waits until the write pipe is empty. Then, if stage<S-1: stage+1, g=0, → READ. Otherwise → DONE.
- DONE: asserts done for one cycle, → IDLE.
- Lane index in stage s: the digit position is p = S-1-s. idx_j = ((g >> 4p) << 4(p+1)) | (j << 4p) | (g mod 16^p).
- Bank mapping: BN = (sum of the log16(N) radix-16 digits of idx) mod 16, 4-bit wrap-around add. MA = idx >> 4.
- Within a group the 16 lanes differ in exactly one digit, so all BN values are distinct. The (BN, MA) mapping is a bijection.
- Write path: a PIPE_LAT-deep shift register holds {valid, 16×MA, 16×BN}. w_enable and R16_w_* are the delayed copies of r_enable and the read addresses.
- Stage hazard: reads of stage s+1 never overlap writes of stage s. This is enforced by DRAIN.
- start while busy: ignored.
- rst at any time: FSM → IDLE, the shift register is cleared, and pending writes are dropped.

## Timing
- Reset values: every output is 0, including all MA/BN lanes, the enables, busy, done, stage_idx and LAST_STAGE.
- All outputs are registered.
- start sampled at cycle 0 → busy=1 and the first r_enable at cycle 1.
- r_enable is high for N/16 consecutive cycles per stage.
- w_enable follows r_enable exactly PIPE_LAT cycles later, with identical addresses.
- The next stage's first read comes the cycle after that stage's last write.
- Per stage: N/16 + PIPE_LAT cycles.
- done pulses at cycle S·(N/16 + PIPE_LAT) + 1. busy drops in the same cycle.
- While r_enable=0, the MA/BN outputs hold their last value. Only the enables qualify them.

## Structure
- Package ntt_agu_pkg holds:
  - constants RADIX=16 and LANES=16;
  - the state enum;
  - function digit_sum_mod16;
  - the lane-array typedefs for MA/BN.
- Sub-module ntt_bank_map: combinational idx → (MA, BN). Instantiated 16 times, once per lane.
- Widths come from `MA_width/`BANK_width in define.svh.

## Test plan
- N=256, PIPE_LAT=4, start at cycle 0:
  - cycle 1 (stage 0, g=0): MAj=j, BNj=j;
  - cycle 16 (g=15): idx_j=16j+15, MAj=j, BNj=(j+15) mod 16;
  - LAST_STAGE=0.
- Same run, stage 1 starts at cycle 21:
  - g=1 at cycle 22: MAj=1, BNj=(1+j) mod 16;
  - LAST_STAGE=1;
  - last write at cycle 40; done=1 at cycle 41, busy=0.
- Write alignment: on every cycle, R16_w_* and w_enable equal the read outputs from 4 cycles earlier. There is no cycle where r_enable=1 in stage 1 while a stage-0 write is still pending.
- Conflict/bijection check, N=4096, PIPE_LAT=1:
  - every issue cycle has 16 distinct BN values;
  - per stage, every (BN, MA) pair appears exactly once;
  - done at cycle 3·257+1 = 772.
- rst asserted at cycle 10 mid-READ: the next cycle has all outputs 0 and no further w_enable. A start at cycle 12 restarts at stage 0, g=0.
- start pulsed again at cycle 5 while busy: ignored, and the sequence and done cycle are unchanged.
